// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one data memory between the processor load/store
// path and a debug/loader port. The processor wins ties unless the debug port
// has lost STARVE_MAX consecutive contended cycles; the debug port can lock the
// memory for multi-word bursts.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  // processor port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  // debug/loader port
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_ack,
  // data memory
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  // statistics
  output logic [CNT_W-1:0]  contention_cnt
);

  localparam int unsigned STARVE_W = $clog2(STARVE_MAX + 1);
  localparam logic [STARVE_W-1:0] STARVE_TOP = STARVE_W'(STARVE_MAX);

  typedef enum logic [0:0] {StFree, StDbgLocked} state_e;

  state_e              state_q, state_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                cpu_gnt, dbg_gnt;

  // Grant decision and next state; grants are suppressed while in reset.
  always_comb begin
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    state_d = state_q;
    if (!rst) begin
      unique case (state_q)
        StFree: begin
          if (cpu_req && !dbg_req) begin
            cpu_gnt = 1'b1;
          end else if (dbg_req && !cpu_req) begin
            dbg_gnt = 1'b1;
          end else if (cpu_req && dbg_req) begin
            if (starve_q == STARVE_TOP) dbg_gnt = 1'b1;
            else                        cpu_gnt = 1'b1;
          end
          if (dbg_gnt && dbg_lock) state_d = StDbgLocked;
        end
        StDbgLocked: begin
          // CPU is locked out; a dropped debug request ends the burst with an idle cycle.
          if (dbg_req) begin
            dbg_gnt = 1'b1;
            if (!dbg_lock) state_d = StFree;
          end else begin
            state_d = StFree;
          end
        end
        default: state_d = StFree;
      endcase
    end
  end

  // Starvation and contention counter next values.
  always_comb begin
    starve_d = starve_q;
    cnt_d    = cnt_q;
    if (!dbg_req || dbg_gnt) begin
      starve_d = '0;
    end else if (cpu_gnt && (starve_q < STARVE_TOP)) begin
      starve_d = starve_q + 1'b1;
    end
    if (cpu_req && dbg_req && !(&cnt_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StFree;
      starve_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      cnt_q    <= cnt_d;
    end
  end

  // Memory-side mux; with no grant the CPU values pass through with writes disabled.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (dbg_gnt) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else if (cpu_gnt) begin
      mem_we    = cpu_we;
    end
  end

  assign cpu_ack        = cpu_gnt;
  assign dbg_ack        = dbg_gnt;
  assign cpu_stall      = cpu_req & ~cpu_gnt & ~rst;
  assign cpu_rdata      = mem_rdata;
  assign dbg_rdata      = mem_rdata;
  assign contention_cnt = cnt_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte-array memory model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_stall;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [31:0] dbg_addr, dbg_wdata, dbg_rdata;
  logic        dbg_ack;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [15:0] contention_cnt;

  // second instance with a narrow statistics counter
  logic [31:0] s_cpu_rdata, s_dbg_rdata, s_mem_addr, s_mem_wdata;
  logic        s_cpu_ack, s_cpu_stall, s_dbg_ack, s_mem_we;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:63];
  logic [5:0] ma;

  dmem_arbiter u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata), .dbg_ack(dbg_ack),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .contention_cnt(contention_cnt)
  );

  dmem_arbiter #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(s_cpu_rdata), .cpu_ack(s_cpu_ack), .cpu_stall(s_cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(s_dbg_rdata), .dbg_ack(s_dbg_ack),
    .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
    .mem_rdata(mem_rdata), .contention_cnt(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // little-endian word memory, combinational read, write at the clock edge
  assign ma        = {mem_addr[5:2], 2'b00};
  assign mem_rdata = {mem[ma + 6'd3], mem[ma + 6'd2], mem[ma + 6'd1], mem[ma]};

  always @(posedge clk) begin
    if (mem_we) begin
      mem[ma]         <= mem_wdata[7:0];
      mem[ma + 6'd1]  <= mem_wdata[15:8];
      mem[ma + 6'd2]  <= mem_wdata[23:16];
      mem[ma + 6'd3]  <= mem_wdata[31:24];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle();
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    cpu_we  = 1'b0; dbg_we  = 1'b0;
  endtask

  // Both request for 4 cycles; the CPU wins each, saturating starvation.
  task automatic contend4(input string tag);
    for (int i = 0; i < 4; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h20;
      dbg_req = 1'b1;
      smp();
      check({tag, "_pre_cpu_ack"}, 64'(cpu_ack), 64'd1);
      check({tag, "_pre_dbg_ack"}, 64'(dbg_ack), 64'd0);
      cyc();
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    cpu_addr = '0; cpu_wdata = '0; dbg_addr = '0; dbg_wdata = '0;
    idle();

    // reset: grants forced off even with both requesting stores
    rst = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1; cpu_we = 1'b1; dbg_we = 1'b1;
    smp();
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rst_dbg_ack", 64'(dbg_ack), 64'd0);
    check("rst_cpu_stall", 64'(cpu_stall), 64'd0);
    cyc();
    cyc();
    rst = 1'b0; idle();
    smp();
    check("rst_cnt", 64'(contention_cnt), 64'd0);
    check("rst_mem0", 64'(mem[0]), 64'd0);
    cyc();

    // CPU only: store then load
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0; cpu_wdata = 32'h0000_00AA;
    smp();
    check("cpu_st_ack", 64'(cpu_ack), 64'd1);
    check("cpu_st_stall", 64'(cpu_stall), 64'd0);
    check("cpu_st_mem_we", 64'(mem_we), 64'd1);
    cyc();
    cpu_we = 1'b0;
    smp();
    check("cpu_ld_ack", 64'(cpu_ack), 64'd1);
    check("cpu_ld_stall", 64'(cpu_stall), 64'd0);
    check("cpu_ld_rdata", 64'(cpu_rdata), 64'h0000_00AA);
    check("cpu_ld_mem_we", 64'(mem_we), 64'd0);
    cyc();

    // debug only: store then load, little-endian byte check
    idle();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h4; dbg_wdata = 32'h1234_5678;
    smp();
    check("dbg_st_ack", 64'(dbg_ack), 64'd1);
    check("dbg_st_cpu_ack", 64'(cpu_ack), 64'd0);
    check("dbg_st_mem_addr", 64'(mem_addr), 64'h4);
    cyc();
    dbg_we = 1'b0;
    smp();
    check("dbg_ld_ack", 64'(dbg_ack), 64'd1);
    check("dbg_ld_rdata", 64'(dbg_rdata), 64'h1234_5678);
    check("dbg_byte4", 64'(mem[4]), 64'h78);
    check("dbg_byte7", 64'(mem[7]), 64'h12);
    cyc();

    // contention: CPU wins 4, debug wins the 5th, CPU wins 6..9
    idle();
    cyc();
    for (int i = 1; i <= 9; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h4;
      smp();
      check($sformatf("cont%0d_cpu_ack", i), 64'(cpu_ack), (i == 5) ? 64'd0 : 64'd1);
      check($sformatf("cont%0d_dbg_ack", i), 64'(dbg_ack), (i == 5) ? 64'd1 : 64'd0);
      check($sformatf("cont%0d_stall", i), 64'(cpu_stall), (i == 5) ? 64'd1 : 64'd0);
      cyc();
    end
    idle();
    smp();
    check("cont_cnt9", 64'(contention_cnt), 64'd9);
    cyc();

    // locked burst: after winning arbitration, debug holds memory for 3 beats
    dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'h0; dbg_wdata = 32'hA0A0_0001;
    contend4("burst");
    for (int b = 0; b < 3; b++) begin
      cpu_req = 1'b1; cpu_we = 1'b0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = (b != 2);
      dbg_addr = 32'(4 * b); dbg_wdata = 32'hA0A0_0001 + 32'(b);
      smp();
      check($sformatf("burst%0d_dbg_ack", b), 64'(dbg_ack), 64'd1);
      check($sformatf("burst%0d_stall", b), 64'(cpu_stall), 64'd1);
      check($sformatf("burst%0d_addr", b), 64'(mem_addr), 64'(4 * b));
      cyc();
    end
    idle(); cpu_req = 1'b1;
    smp();
    check("burst_after_cpu_ack", 64'(cpu_ack), 64'd1);
    check("burst_byte8", 64'(mem[8]), 64'h03);
    check("burst_byte4", 64'(mem[4]), 64'h02);
    cyc();

    // locked burst with debug request dropped mid-burst
    idle();
    cyc();
    dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'h10; dbg_wdata = 32'h5555_AAAA;
    contend4("drop");
    smp();
    check("drop_beat_dbg_ack", 64'(dbg_ack), 64'd1);
    cyc();
    dbg_req = 1'b0; cpu_req = 1'b1;
    smp();
    check("drop_idle_cpu_ack", 64'(cpu_ack), 64'd0);
    check("drop_idle_dbg_ack", 64'(dbg_ack), 64'd0);
    check("drop_idle_stall", 64'(cpu_stall), 64'd1);
    check("drop_idle_mem_we", 64'(mem_we), 64'd0);
    cyc();
    smp();
    check("drop_after_cpu_ack", 64'(cpu_ack), 64'd1);
    check("drop_after_stall", 64'(cpu_stall), 64'd0);
    cyc();

    // reset in the second beat of a locked burst
    idle();
    cyc();
    dbg_we = 1'b1; dbg_lock = 1'b1; dbg_addr = 32'h18; dbg_wdata = 32'h0BAD_F00D;
    contend4("rstb");
    smp();
    check("rstb_beat1_dbg_ack", 64'(dbg_ack), 64'd1);
    cyc();
    rst = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h24; cpu_wdata = 32'hCAFE_0001;
    dbg_addr = 32'h28; dbg_wdata = 32'hDEAD_BEEF;
    smp();
    check("rstb_mem_we", 64'(mem_we), 64'd0);
    check("rstb_dbg_ack", 64'(dbg_ack), 64'd0);
    check("rstb_cpu_ack", 64'(cpu_ack), 64'd0);
    check("rstb_stall", 64'(cpu_stall), 64'd0);
    cyc();
    rst = 1'b0; cpu_we = 1'b0; dbg_we = 1'b0;
    smp();
    check("rstb_cnt", 64'(contention_cnt), 64'd0);
    check("rstb_cpu_ack", 64'(cpu_ack), 64'd1);
    check("rstb_dbg_ack_post", 64'(dbg_ack), 64'd0);
    check("rstb_mem24", 64'(mem[36]), 64'h00);
    check("rstb_mem28", 64'(mem[40]), 64'h00);
    cyc();

    // counter saturation: 20 contended cycles
    idle(); rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cpu_req = 1'b1; dbg_req = 1'b1;
      cyc();
      if (i == 14) check("sat_cnt4_at15", 64'(s_cnt), 64'd15);
    end
    idle();
    smp();
    check("sat_cnt4", 64'(s_cnt), 64'd15);
    check("sat_cnt16", 64'(contention_cnt), 64'd20);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory (DataMem1) between two requesters: the processor load/store path and a debug/loader port that preloads and inspects memory.
- The processor has priority. A bounded-starvation counter guarantees the debug port progress, and a lock mechanism supports multi-word debug bursts.
- When the processor loses arbitration it receives a stall. The stall must freeze PC_cs and suppress the register-file writeback for that cycle.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, word width. Memory is little-endian: byte addr+0 is bits 7:0.
- STARVE_MAX, 4, number of consecutive contended cycles the debug port can lose before it is forced a grant.
- CNT_W, 16, width of the contention statistics counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cpu_req  in  1  processor memory access this cycle (load or store).
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  ADDR_W  processor byte address.
- cpu_wdata  in  DATA_W  processor store data.
- cpu_rdata  out  DATA_W  load data; valid when cpu_ack = 1.
- cpu_ack  out  1  processor access performed this cycle.
- cpu_stall  out  1  processor must hold PC and retry next cycle.
- dbg_req  in  1  debug access request.
- dbg_we  in  1  debug store.
- dbg_lock  in  1  keep ownership after this access (burst).
- dbg_addr  in  ADDR_W  debug byte address.
- dbg_wdata  in  DATA_W  debug store data.
- dbg_rdata  out  DATA_W  debug load data; valid when dbg_ack = 1.
- dbg_ack  out  1  debug access performed this cycle.
- mem_we  out  1  write enable to data memory; the write commits at the clk edge.
- mem_addr  out  ADDR_W  address to data memory.
- mem_wdata  out  DATA_W  write data to data memory.
- mem_rdata  in  DATA_W  combinational read data from memory.
- contention_cnt  out  CNT_W  saturating count of cycles in which both requesters asserted req.

Behaviour:

State machine:
- States: FREE, DBG_LOCKED. Registered state: state, starve (0..STARVE_MAX), contention_cnt.

Grant rules (combinational, same cycle):
- In FREE:
  - Only one requester asserts req: that requester is granted.
  - Both assert req and starve < STARVE_MAX: the CPU is granted.
  - Both assert req and starve == STARVE_MAX: debug is granted.
- In DBG_LOCKED: debug is always granted if dbg_req = 1. The CPU is never granted, even if dbg_req = 0.

Outputs:
- The granted requester drives mem_addr, mem_wdata and mem_we (its own we). With no grant, mem_we = 0 and mem_addr/mem_wdata = the CPU values.
- cpu_ack = cpu grant. dbg_ack = debug grant.
- cpu_rdata and dbg_rdata = mem_rdata (combinational, zero latency). The requester must qualify the data with its ack.
- cpu_stall = cpu_req & ~cpu_ack.

Transitions:
- FREE -> DBG_LOCKED when debug is granted with dbg_lock = 1.
- DBG_LOCKED -> FREE on a debug grant with dbg_lock = 0.
- DBG_LOCKED -> FREE on any cycle with dbg_req = 0. That cycle grants nobody, and the CPU stalls if it requests.

Starvation counter:
- Increments (saturating at STARVE_MAX) in cycles where dbg_req = 1 and the CPU is granted.
- Clears to 0 on any debug grant, or whenever dbg_req = 0.

contention_cnt:
- Increments when cpu_req & dbg_req, in any state.
- Saturates at all-ones; it does not wrap.

Reset:
- While rst = 1:
  - Grants are forced to 0: mem_we = 0, cpu_ack = 0, dbg_ack = 0, cpu_stall = 0.
  - Next state is FREE, starve = 0, contention_cnt = 0.
- Reset during DBG_LOCKED abandons the burst; the first post-reset cycle is arbitrated from FREE.
- No memory write occurs in any cycle with rst = 1.

Other rules:
- Exactly one memory write is possible per cycle; the arbiter never produces two grants.
- Addresses pass through unmodified. Alignment is the requester's responsibility.

Test Plan:
- CPU only: cpu_req=1, cpu_we=1, addr 0, wdata 0x0000_00AA, then a load from 0 -> cpu_ack=1 both cycles, cpu_stall=0, bytes 3..0 of memory read back 0x0000_00AA.
- Debug only: dbg store 0x1234_5678 to addr 4 -> dbg_ack=1. The next load from addr 4 gives dbg_rdata=0x1234_5678, byte 4 = 0x78 (little-endian).
- Contention, STARVE_MAX=4: both request continuously.
  - Cycles 1-4: CPU granted.
  - Cycle 5: debug granted and cpu_stall=1.
  - Cycles 6-9: CPU granted again (starve cleared).
  - contention_cnt = 9 after 9 cycles.
- Locked burst: debug writes addresses 0,4,8 with dbg_lock=1,1,0 while cpu_req=1 -> debug granted 3 cycles with cpu_stall=1 throughout, then the CPU is granted in cycle 4. In a repeat run, dropping dbg_req mid-burst -> one idle cycle with cpu_stall=1, then the CPU is granted.
- Reset mid-burst: assert rst in the second cycle of a locked burst with cpu_we=1 and dbg_we=1 -> no memory write occurs, counters read 0 after release, and the first post-reset cycle with both requesting grants the CPU.
- Saturation: with CNT_W=4, hold contention for 20 cycles -> contention_cnt stops at 15.
